// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared constants and types for the MIPS writeback sequencer.
//   DATA_W     register data width
//   ADDR_W     register address width (2**ADDR_W architectural registers)
//   REG_ZERO   address of the hard-wired zero register
//   wb_entry_t one pending register write {addr, data}
package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage : mips_wb_pkg

// File: rtl/wb_fifo.sv
// wb_fifo: circular buffer of wb_entry_t for long-latency results.
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_entry at the tail (ignored when full)
//   push_entry   entry to store
//   pop          drop the head entry (ignored when empty)
//   head         current head entry (valid when !empty)
//   full, empty  occupancy flags
//   count        number of buffered entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule : wb_fifo

// File: rtl/wb_write_sequencer.sv
// wb_write_sequencer: sole writer of the register file write port.
//   pipe_*       in-order writeback results (highest priority, no backpressure)
//   lu_*         long-latency results via valid/ready into a small FIFO
//   claim_*      long-latency issue, marks destination as pending
//   RegWrite, write_addr, write_data  registered write port
//   pending      bit r set while a long-latency result for r is outstanding
//   fifo_count   buffered long-latency results
// DATA_W/ADDR_W must match the mips_wb_pkg constants (wb_entry_t is fixed).
module wb_write_sequencer #(
  parameter int DATA_W     = mips_wb_pkg::DATA_W,
  parameter int ADDR_W     = mips_wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_valid,
  input  logic [ADDR_W-1:0]             pipe_addr,
  input  logic [DATA_W-1:0]             pipe_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_W-1:0]             lu_addr,
  input  logic [DATA_W-1:0]             lu_data,
  input  logic                          claim_valid,
  input  logic [ADDR_W-1:0]             claim_addr,
  output logic                          RegWrite,
  output logic [ADDR_W-1:0]             write_addr,
  output logic [DATA_W-1:0]             write_data,
  output logic [(2**ADDR_W)-1:0]        pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import mips_wb_pkg::*;

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t         lu_entry;
  wb_entry_t         fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   pending_q, pending_d;

  // Ready is forced low during reset so nothing is accepted then.
  assign lu_ready       = rst_n & ~fifo_full;
  assign fifo_push      = lu_valid & lu_ready;
  assign lu_entry.addr  = lu_addr;
  assign lu_entry.data  = lu_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_entry (lu_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Write source selection: pipeline first, then buffered results.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = {ADDR_W{1'b0}};
    sel_data  = {DATA_W{1'b0}};
    fifo_pop  = 1'b0;
    if (pipe_valid) begin
      sel_valid = 1'b1;
      sel_addr  = pipe_addr;
      sel_data  = pipe_data;
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      sel_valid = 1'b1;
      sel_addr  = fifo_head.addr;
      sel_data  = fifo_head.data;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Write port next state and scoreboard update.
  always_comb begin
    regwrite_d   = sel_valid & (sel_addr != REG_ZERO);
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    pending_d    = pending_q;
    if (sel_valid) begin
      write_addr_d = sel_addr;
      write_data_d = sel_data;
    end else begin
      write_addr_d = write_addr_q;
      write_data_d = write_data_q;
    end
    // Only buffered results retire a claim; pipeline writes leave it alone.
    if (fifo_pop) begin
      pending_d[fifo_head.addr] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    // Applied after the clear so a same-cycle claim wins.
    if (claim_valid && (claim_addr != REG_ZERO)) begin
      pending_d[claim_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[0] = 1'b0;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q   <= 1'b0;
      write_addr_q <= {ADDR_W{1'b0}};
      write_data_q <= {DATA_W{1'b0}};
      pending_q    <= {NREG{1'b0}};
    end else begin
      regwrite_q   <= regwrite_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign RegWrite   = regwrite_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign pending    = pending_q;

endmodule : wb_write_sequencer

// File: tb/tb_wb_write_sequencer.sv
// Self-checking bench for wb_write_sequencer: directed steps plus a
// scoreboard of expected register-file writes checked on every falling edge.
module tb_wb_write_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_valid;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_addr;
  logic [DW-1:0] lu_data;
  logic          claim_valid;
  logic [AW-1:0] claim_addr;
  logic          RegWrite;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [31:0]   pending;
  logic [2:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  exp_wr_t exp_q[$];

  wb_write_sequencer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_valid  (pipe_valid),
    .pipe_addr   (pipe_addr),
    .pipe_data   (pipe_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_addr     (lu_addr),
    .lu_data     (lu_data),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .RegWrite    (RegWrite),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .pending     (pending),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_when_none_expected", {63'd0, RegWrite}, 64'd0);
      end else begin
        exp_wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {59'd0, write_addr}, {59'd0, e.addr});
        chk("wr_data", {32'd0, write_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    logic [AW-1:0] acc_addr[$];
    logic [DW-1:0] acc_data[$];
    int lu_idx;

    rst_n = 1'b0; pipe_valid = 1'b0; pipe_addr = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0; claim_valid = 1'b0; claim_addr = '0;
    #2;
    chk("rst_lu_ready", {63'd0, lu_ready}, 64'd0);
    cyc(); cyc();
    chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("rst_write_addr", {59'd0, write_addr}, 64'd0);
    chk("rst_write_data", {32'd0, write_data}, 64'd0);
    chk("rst_pending", {32'd0, pending}, 64'd0);
    chk("rst_count", {61'd0, fifo_count}, 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("idle_lu_ready", {63'd0, lu_ready}, 64'd1);
    chk("idle_pending", {32'd0, pending}, 64'd0);

    // Pipeline write, then the same request to the zero register.
    pipe_valid = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h0000_1234;
    expect_wr(5'd8, 32'h0000_1234);
    cyc();
    pipe_valid = 1'b0;
    chk("pipe_regwrite", {63'd0, RegWrite}, 64'd1);
    chk("pipe_addr8", {59'd0, write_addr}, 64'd8);
    pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h0000_1234;
    cyc();
    pipe_valid = 1'b0;
    chk("zero_reg_no_write", {63'd0, RegWrite}, 64'd0);
    cyc();
    chk("hold_regwrite_low", {63'd0, RegWrite}, 64'd0);

    // Claim, long-latency return, retire.
    claim_valid = 1'b1; claim_addr = 5'd5;
    cyc();
    claim_valid = 1'b0;
    chk("claim5_pending", {63'd0, pending[5]}, 64'd1);
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hDEAD;
    expect_wr(5'd5, 32'hDEAD);
    cyc();
    lu_valid = 1'b0;
    chk("lu_pushed_count", {61'd0, fifo_count}, 64'd1);
    chk("lu_not_yet_written", {63'd0, RegWrite}, 64'd0);
    chk("pending5_still", {63'd0, pending[5]}, 64'd1);
    cyc();
    chk("lu_written", {63'd0, RegWrite}, 64'd1);
    chk("lu_write_addr", {59'd0, write_addr}, 64'd5);
    chk("pending5_cleared", {63'd0, pending[5]}, 64'd0);
    chk("lu_drained", {61'd0, fifo_count}, 64'd0);

    // Six busy pipeline cycles while five results are offered.
    lu_idx = 0;
    for (int i = 0; i < 6; i++) begin
      pipe_valid = 1'b1; pipe_addr = AW'(10 + i); pipe_data = 32'hA000 + DW'(i);
      expect_wr(AW'(10 + i), 32'hA000 + DW'(i));
      if (lu_idx < 5) begin
        lu_valid = 1'b1; lu_addr = AW'(20 + lu_idx); lu_data = 32'hB000 + DW'(lu_idx);
      end else begin
        lu_valid = 1'b0;
      end
      #1;
      if (lu_valid && lu_ready) begin
        acc_addr.push_back(lu_addr);
        acc_data.push_back(lu_data);
        lu_idx++;
      end
      if (i == 5) chk("full_lu_ready", {63'd0, lu_ready}, 64'd0);
      cyc();
    end
    pipe_valid = 1'b0; lu_valid = 1'b0;
    chk("accepted_four", 64'(acc_addr.size()), 64'd4);
    chk("count_full", {61'd0, fifo_count}, 64'd4);
    while (acc_addr.size() > 0) expect_wr(acc_addr.pop_front(), acc_data.pop_front());
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_count", {61'd0, fifo_count}, 64'(3 - i));
    end
    cyc();
    chk("drained_idle", {63'd0, RegWrite}, 64'd0);

    // Same-cycle claim and retire of register 9: claim wins.
    claim_valid = 1'b1; claim_addr = 5'd9;
    cyc();
    claim_valid = 1'b0;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9999;
    expect_wr(5'd9, 32'h9999);
    cyc();
    lu_valid = 1'b0;
    claim_valid = 1'b1; claim_addr = 5'd9;
    cyc();
    claim_valid = 1'b0;
    chk("claim_beats_clear", {63'd0, pending[9]}, 64'd1);

    // Buffer three entries behind zero-register pipe traffic, then reset.
    pipe_valid = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h1;
    claim_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      claim_addr = AW'(3 + i);
      lu_valid = 1'b1; lu_addr = AW'(3 + i); lu_data = 32'hC000 + DW'(i);
      cyc();
    end
    claim_valid = 1'b0; lu_valid = 1'b0;
    chk("buffered_three", {61'd0, fifo_count}, 64'd3);
    chk("pending_before_rst", {32'd0, pending}, 64'h0000_0238);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", {61'd0, fifo_count}, 64'd0);
    chk("async_rst_pending", {32'd0, pending}, 64'd0);
    chk("async_rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("async_rst_lu_ready", {63'd0, lu_ready}, 64'd0);
    pipe_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("post_rst_count", {61'd0, fifo_count}, 64'd0);
    chk("post_rst_regwrite", {63'd0, RegWrite}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_write_sequencer
